// File: rtl/bc_game_sequencer.sv
// Bulls & Cows two-player turn controller: secret entry, guess validation,
// scoring-unit handshake, result hold, win/draw detection and win tallies.
module bc_game_sequencer #(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int MAX_TURNS   = 10,
   parameter int WIN_W       = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             confirm_tick,
   input  logic [15:0]      entry,
   output logic             score_start,
   output logic [15:0]      score_guess,
   output logic [15:0]      score_secret,
   input  logic             score_done,
   input  logic [2:0]       score_bulls,
   input  logic [2:0]       score_cows,
   output logic [3:0]       phase,
   output logic             player,
   output logic [2:0]       last_bulls,
   output logic [2:0]       last_cows,
   output logic [3:0]       turn_cnt,
   output logic [WIN_W-1:0] wins_j1,
   output logic [WIN_W-1:0] wins_j2
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [3:0]        TURN_MAX  = 4'(MAX_TURNS);

   // Encoding doubles as the phase code seen by the display encoder.
   typedef enum logic [3:0] {
      ST_SET_J1 = 4'd0,
      ST_SET_J2 = 4'd1,
      ST_TURN   = 4'd2,
      ST_SCORE  = 4'd3,
      ST_SHOW   = 4'd4,
      ST_ERR    = 4'd5,
      ST_WIN    = 4'd6,
      ST_DRAW   = 4'd7
   } state_t;

   state_t            state, state_nxt, ret_state, ret_state_nxt;
   logic              player_nxt, score_start_nxt;
   logic [15:0]       secret_j1, secret_j1_nxt, secret_j2, secret_j2_nxt;
   logic [15:0]       score_guess_nxt, score_secret_nxt;
   logic [3:0]        cnt_j1, cnt_j1_nxt, cnt_j2, cnt_j2_nxt, turn_cnt_nxt;
   logic [2:0]        last_bulls_nxt, last_cows_nxt;
   logic [WIN_W-1:0]  wins_j1_nxt, wins_j2_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic              entry_valid;

   // Four BCD digits, each 0..9, no digit repeated.
   function automatic logic entry_ok(input logic [15:0] e);
      logic [3:0] d [4];
      logic       ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) d[i] = e[4*i +: 4];
      for (int i = 0; i < 4; i++) begin
         if (d[i] > 4'd9) ok = 1'b0;
         for (int j = i + 1; j < 4; j++)
            if (d[i] == d[j]) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [3:0] turn_inc(input logic [3:0] c);
      return (c >= TURN_MAX) ? c : c + 4'd1;
   endfunction

   function automatic logic [WIN_W-1:0] win_inc(input logic [WIN_W-1:0] w);
      return (&w) ? w : w + 1'b1;
   endfunction

   assign entry_valid = entry_ok(entry);
   assign phase       = state;

   always_comb begin
      state_nxt        = state;
      ret_state_nxt    = ret_state;
      player_nxt       = player;
      score_start_nxt  = 1'b0;
      secret_j1_nxt    = secret_j1;
      secret_j2_nxt    = secret_j2;
      score_guess_nxt  = score_guess;
      score_secret_nxt = score_secret;
      cnt_j1_nxt       = cnt_j1;
      cnt_j2_nxt       = cnt_j2;
      last_bulls_nxt   = last_bulls;
      last_cows_nxt    = last_cows;
      wins_j1_nxt      = wins_j1;
      wins_j2_nxt      = wins_j2;

      case (state)
         ST_SET_J1: if (confirm_tick) begin
            if (entry_valid) begin
               secret_j1_nxt = entry;
               state_nxt     = ST_SET_J2;
            end else begin
               ret_state_nxt = ST_SET_J1;
               state_nxt     = ST_ERR;
            end
         end
         ST_SET_J2: if (confirm_tick) begin
            if (entry_valid) begin
               secret_j2_nxt = entry;
               player_nxt    = 1'b0;
               state_nxt     = ST_TURN;
            end else begin
               ret_state_nxt = ST_SET_J2;
               state_nxt     = ST_ERR;
            end
         end
         ST_TURN: if (confirm_tick) begin
            if (entry_valid) begin
               score_guess_nxt  = entry;
               score_secret_nxt = player ? secret_j1 : secret_j2;
               score_start_nxt  = 1'b1;
               state_nxt        = ST_SCORE;
            end else begin
               ret_state_nxt = ST_TURN;
               state_nxt     = ST_ERR;
            end
         end
         ST_SCORE: if (score_done) begin
            last_bulls_nxt = score_bulls;
            last_cows_nxt  = score_cows;
            if (player) cnt_j2_nxt = turn_inc(cnt_j2);
            else        cnt_j1_nxt = turn_inc(cnt_j1);
            if (score_bulls == 3'd4) begin
               if (player) wins_j2_nxt = win_inc(wins_j2);
               else        wins_j1_nxt = win_inc(wins_j1);
               state_nxt = ST_WIN;
            end else begin
               state_nxt = ST_SHOW;
            end
         end
         ST_SHOW: if (hold_cnt == HOLD_LAST) begin
            if (cnt_j1 == TURN_MAX && cnt_j2 == TURN_MAX) begin
               state_nxt = ST_DRAW;
            end else begin
               player_nxt = ~player;
               state_nxt  = ST_TURN;
            end
         end
         ST_ERR: if (hold_cnt == HOLD_LAST) state_nxt = ret_state;
         ST_WIN, ST_DRAW: if (confirm_tick) begin
            state_nxt      = ST_SET_J1;
            player_nxt     = 1'b0;
            secret_j1_nxt  = '0;
            secret_j2_nxt  = '0;
            cnt_j1_nxt     = '0;
            cnt_j2_nxt     = '0;
            last_bulls_nxt = '0;
            last_cows_nxt  = '0;
         end
         default: state_nxt = ST_SET_J1;
      endcase

      // Hold timer runs only while parked in SHOW/ERR; any transition restarts it.
      if (state_nxt == state && (state == ST_SHOW || state == ST_ERR))
         hold_cnt_nxt = hold_cnt + 1'b1;
      else
         hold_cnt_nxt = '0;

      turn_cnt_nxt = player_nxt ? cnt_j2_nxt : cnt_j1_nxt;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_SET_J1;
         ret_state    <= ST_SET_J1;
         player       <= 1'b0;
         score_start  <= 1'b0;
         secret_j1    <= '0;
         secret_j2    <= '0;
         score_guess  <= '0;
         score_secret <= '0;
         cnt_j1       <= '0;
         cnt_j2       <= '0;
         turn_cnt     <= '0;
         last_bulls   <= '0;
         last_cows    <= '0;
         wins_j1      <= '0;
         wins_j2      <= '0;
         hold_cnt     <= '0;
      end else begin
         state        <= state_nxt;
         ret_state    <= ret_state_nxt;
         player       <= player_nxt;
         score_start  <= score_start_nxt;
         secret_j1    <= secret_j1_nxt;
         secret_j2    <= secret_j2_nxt;
         score_guess  <= score_guess_nxt;
         score_secret <= score_secret_nxt;
         cnt_j1       <= cnt_j1_nxt;
         cnt_j2       <= cnt_j2_nxt;
         turn_cnt     <= turn_cnt_nxt;
         last_bulls   <= last_bulls_nxt;
         last_cows    <= last_cows_nxt;
         wins_j1      <= wins_j1_nxt;
         wins_j2      <= wins_j2_nxt;
         hold_cnt     <= hold_cnt_nxt;
      end
   end

endmodule
